// File: rtl/rom_dl_sdram_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : rom_dl_sdram_writer_if
//  Description : SDRAM write port between the ROM download writer (master)
//                and the SDRAM arbiter/controller (slave). req is a level held
//                until a one-cycle ack; addr/data are stable while req is high.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rom_dl_sdram_writer_if #(
    parameter int SDRAM_AW = 24
);
    logic                sdram_wr_req;
    logic [SDRAM_AW-1:0] sdram_wr_addr;
    logic [15:0]         sdram_wr_data;
    logic                sdram_wr_ack;

    modport master (
        output sdram_wr_req,
        output sdram_wr_addr,
        output sdram_wr_data,
        input  sdram_wr_ack
    );

    modport slave (
        input  sdram_wr_req,
        input  sdram_wr_addr,
        input  sdram_wr_data,
        output sdram_wr_ack
    );
endinterface
`default_nettype wire

// File: rtl/rom_dl_sdram_writer.sv
`default_nettype none
// ============================================================================
//  Module      : rom_dl_sdram_writer
//  Description : Accepts region-tagged ROM download word writes, relocates
//                them to flat SDRAM word addresses, buffers them in a small
//                FIFO and drains the FIFO over a req/ack SDRAM write port.
//                Throttles the HPS download through ioctl_wait.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_dl_sdram_writer #(
    parameter int                  FIFO_AW    = 3,
    parameter int                  SDRAM_AW   = 24,
    parameter logic [SDRAM_AW-1:0] BASE_68K   = 24'h000000,
    parameter logic [SDRAM_AW-1:0] BASE_Z80   = 24'h040000,
    parameter logic [SDRAM_AW-1:0] BASE_TILES = 24'h080000,
    parameter logic [SDRAM_AW-1:0] BASE_SPR   = 24'h100000,
    parameter logic [SDRAM_AW-1:0] BASE_K7232 = 24'h300000,
    parameter logic [SDRAM_AW-1:0] BASE_THEME = 24'h380000,
    parameter logic [SDRAM_AW-1:0] BASE_UPD   = 24'h3C0000
) (
    input  wire         clk_sys,
    input  wire         reset_n,
    input  wire         load_en,
    input  wire         rom_68k_we,
    input  wire         rom_z80_we,
    input  wire         rom_tiles_we,
    input  wire         rom_sprites_we,
    input  wire         rom_007232_we,
    input  wire         rom_theme_we,
    input  wire         rom_uPD7759C_we,
    input  wire  [25:0] rom_addr,
    input  wire  [15:0] rom_data,
    output logic        ioctl_wait,
    output logic        dl_done,
    output logic        err_multi,
    output logic        err_ovf,
    rom_dl_sdram_writer_if.master sdram
);

    localparam int                 DEPTH        = 1 << FIFO_AW;
    localparam int                 WORD_W       = SDRAM_AW + 16;
    localparam logic [FIFO_AW:0]   C_DEPTH      = (FIFO_AW+1)'(DEPTH);
    // Raise wait with two free slots left so writes already in flight from
    // the HPS side still fit.
    localparam logic [FIFO_AW:0]   C_WAIT_LEVEL = (FIFO_AW+1)'(DEPTH - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Strobe decode and relocation
    // ------------------------------------------------------------------
    logic [6:0]          w_we;
    logic [2:0]          w_sel;
    logic                w_any;
    logic                w_multi;
    logic [SDRAM_AW-1:0] w_base;
    logic [SDRAM_AW-1:0] w_reloc;
    logic                w_unused_addr_hi;

    assign w_we = {rom_uPD7759C_we, rom_theme_we, rom_007232_we, rom_sprites_we,
                   rom_tiles_we, rom_z80_we, rom_68k_we};
    assign w_any   = |w_we;
    assign w_multi = (w_we & (w_we - 7'd1)) != 7'd0;
    // Upper offset bits beyond the SDRAM word space fall away in the wrap.
    assign w_unused_addr_hi = ^rom_addr[25:SDRAM_AW];

    // Lowest-index strobe wins: scan downward so the last hit is the lowest.
    always_comb begin
        w_sel = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (w_we[i]) begin
                w_sel = 3'(i);
            end
        end
    end

    // Region base lookup for the winning strobe.
    always_comb begin
        w_base = BASE_68K;
        case (w_sel)
            3'd0:    w_base = BASE_68K;
            3'd1:    w_base = BASE_Z80;
            3'd2:    w_base = BASE_TILES;
            3'd3:    w_base = BASE_SPR;
            3'd4:    w_base = BASE_K7232;
            3'd5:    w_base = BASE_THEME;
            default: w_base = BASE_UPD;
        endcase
    end

    assign w_reloc = w_base + rom_addr[SDRAM_AW-1:0];

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [WORD_W-1:0]   r_mem [DEPTH];
    logic [FIFO_AW-1:0]  r_wr_ptr;
    logic [FIFO_AW-1:0]  r_rd_ptr;
    logic [FIFO_AW:0]    r_count;
    logic [FIFO_AW:0]    w_count_nxt;
    logic                w_push_req;
    logic                w_push;
    logic                w_drop;
    logic                w_pop;
    logic                w_full;
    logic [WORD_W-1:0]   w_head;

    assign w_push_req  = load_en && w_any;
    assign w_full      = (r_count == C_DEPTH);
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // is only lost when nothing drains.
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_drop      = w_push_req && !w_push;
    assign w_count_nxt = r_count + {{FIFO_AW{1'b0}}, w_push} - {{FIFO_AW{1'b0}}, w_pop};
    assign w_head      = r_mem[r_rd_ptr];

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_reloc, rom_data};
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Drain FSM
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_load;
    logic                w_req;
    logic [SDRAM_AW-1:0] r_addr;
    logic [15:0]         r_data;

    // State register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, head load, pop and request generation.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_pop       = 1'b0;
        w_req       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                w_req = 1'b1;
                if (sdram.sdram_wr_ack) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Address/data held stable for the whole request.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_addr <= '0;
            r_data <= '0;
        end else if (w_load) begin
            {r_addr, r_data} <= w_head;
        end
    end

    // ------------------------------------------------------------------
    // Status outputs
    // ------------------------------------------------------------------
    logic r_ioctl_wait;
    logic r_dl_done;
    logic r_err_multi;
    logic r_err_ovf;
    logic r_load_en_d;
    logic w_le_rise;

    assign w_le_rise = load_en && !r_load_en_d;

    // Backpressure and completion flags, both registered.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_ioctl_wait <= 1'b0;
            r_dl_done    <= 1'b0;
            r_load_en_d  <= 1'b0;
        end else begin
            r_ioctl_wait <= load_en && (w_count_nxt >= C_WAIT_LEVEL);
            r_dl_done    <= !load_en && (r_count == '0) && (r_state == S_IDLE);
            r_load_en_d  <= load_en;
        end
    end

    // Sticky error flags; a new download window clears them, but an error
    // in that very first cycle still sets them.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_err_multi <= 1'b0;
            r_err_ovf   <= 1'b0;
        end else begin
            if (w_le_rise) begin
                r_err_multi <= 1'b0;
                r_err_ovf   <= 1'b0;
            end
            if (w_push_req && w_multi) r_err_multi <= 1'b1;
            if (w_drop)                r_err_ovf   <= 1'b1;
        end
    end

    assign ioctl_wait          = r_ioctl_wait;
    assign dl_done             = r_dl_done;
    assign err_multi           = r_err_multi;
    assign err_ovf             = r_err_ovf;
    assign sdram.sdram_wr_req  = w_req;
    assign sdram.sdram_wr_addr = r_addr;
    assign sdram.sdram_wr_data = r_data;

endmodule
`default_nettype wire

// File: tb/tb_rom_dl_sdram_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_dl_sdram_writer
//  Description : Directed bench for rom_dl_sdram_writer with a queue-based
//                reference model checked every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_dl_sdram_writer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load_en = 1'b0;
    logic [6:0]  we = 7'd0;
    logic [25:0] rom_addr = 26'd0;
    logic [15:0] rom_data = 16'd0;
    logic        ioctl_wait, dl_done, err_multi, err_ovf;
    logic        ack_en = 1'b0;
    logic        ack_force = 1'b0;

    int n_vec  = 0;
    int n_fail = 0;
    int nedge  = 0;

    rom_dl_sdram_writer_if #(.SDRAM_AW(24)) sd ();

    rom_dl_sdram_writer dut (
        .clk_sys         (clk),
        .reset_n         (reset_n),
        .load_en         (load_en),
        .rom_68k_we      (we[0]),
        .rom_z80_we      (we[1]),
        .rom_tiles_we    (we[2]),
        .rom_sprites_we  (we[3]),
        .rom_007232_we   (we[4]),
        .rom_theme_we    (we[5]),
        .rom_uPD7759C_we (we[6]),
        .rom_addr        (rom_addr),
        .rom_data        (rom_data),
        .ioctl_wait      (ioctl_wait),
        .dl_done         (dl_done),
        .err_multi       (err_multi),
        .err_ovf         (err_ovf),
        .sdram           (sd.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) nedge <= nedge + 1;

    // Controller stand-in: one-cycle ack to each request, plus a forced pulse.
    always @(posedge clk) begin
        #2;
        sd.sdram_wr_ack = (ack_en && sd.sdram_wr_req) || ack_force;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] base_of(input int idx);
        case (idx)
            0: return 24'h000000;
            1: return 24'h040000;
            2: return 24'h080000;
            3: return 24'h100000;
            4: return 24'h300000;
            5: return 24'h380000;
            default: return 24'h3C0000;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Reference model: queue of pending words with push edge stamps.
    // ------------------------------------------------------------------
    logic [39:0] mq[$];
    int          ms[$];
    logic        exp_io = 1'b0, exp_done = 1'b0, exp_em = 1'b0, exp_eo = 1'b0;
    logic        popped_last = 1'b0, prev_le = 1'b0;

    always @(negedge clk) begin
        logic        pop;
        logic        allowed;
        logic        done_n;
        logic        found;
        int          idx;
        logic [23:0] a;
        if (!reset_n) begin
            check("rst_req", sd.sdram_wr_req, 1'b0);
            check("rst_ioctl_wait", ioctl_wait, 1'b0);
            check("rst_dl_done", dl_done, 1'b0);
            check("rst_err_multi", err_multi, 1'b0);
            check("rst_err_ovf", err_ovf, 1'b0);
            mq.delete();
            ms.delete();
            exp_io = 0; exp_done = 0; exp_em = 0; exp_eo = 0;
            popped_last = 0; prev_le = 0;
        end else begin
            check("ioctl_wait", ioctl_wait, exp_io);
            check("dl_done", dl_done, exp_done);
            check("err_multi", err_multi, exp_em);
            check("err_ovf", err_ovf, exp_eo);
            // A request is legal only for an entry pushed on an earlier edge
            // and never in the cycle right after a completed write.
            allowed = (mq.size() > 0) && !popped_last && (ms[0] < nedge);
            check("req_legal", sd.sdram_wr_req & ~allowed, 1'b0);
            if (sd.sdram_wr_req && mq.size() > 0)
                check("wr_word", {sd.sdram_wr_addr, sd.sdram_wr_data}, mq[0]);

            pop    = sd.sdram_wr_req && sd.sdram_wr_ack && (mq.size() > 0);
            done_n = !load_en && (mq.size() == 0) && !popped_last;
            if (load_en && !prev_le) begin
                exp_em = 0;
                exp_eo = 0;
            end
            if (pop) begin
                void'(mq.pop_front());
                void'(ms.pop_front());
            end
            if (load_en && we != 7'd0) begin
                found = 0;
                idx   = 0;
                for (int i = 0; i < 7; i++) begin
                    if (we[i] && !found) begin
                        idx   = i;
                        found = 1;
                    end
                end
                a = base_of(idx) + rom_addr[23:0];
                if (mq.size() < 8) begin
                    mq.push_back({a, rom_data});
                    ms.push_back(nedge + 1);
                end else begin
                    exp_eo = 1;
                end
                if ($countones(we) > 1) exp_em = 1;
            end
            exp_io      = load_en && (mq.size() >= 6);
            exp_done    = done_n;
            popped_last = pop;
            prev_le     = load_en;
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [6:0] m, input logic [25:0] a, input logic [15:0] d);
        we = m; rom_addr = a; rom_data = d;
        step();
        we = 7'd0;
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 40 && !sd.sdram_wr_req; i++) step();
        check({"wait_req_", tag}, sd.sdram_wr_req, 1'b1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 80 && (mq.size() != 0 || sd.sdram_wr_req); i++) step();
        check({"drained_", tag}, mq.size(), 0);
    endtask

    initial begin
        repeat (3) step();
        reset_n = 1'b1;
        step(); step();
        check("idle_dl_done", dl_done, 1'b1);
        check("idle_ioctl_wait", ioctl_wait, 1'b0);

        // 1: single Z80 write
        load_en = 1'b1;
        step();
        wr(7'b0000010, 26'h10, 16'hBEEF);
        wait_req("t1");
        check("t1_addr", sd.sdram_wr_addr, 24'h040010);
        check("t1_data", sd.sdram_wr_data, 16'hBEEF);
        ack_en = 1'b1;
        step();
        check("t1_req_drop", sd.sdram_wr_req, 1'b0);
        check("t1_dl_done", dl_done, 1'b0);
        ack_en = 1'b0;
        step(); step();

        // 2: eight back-to-back 68k writes with no ack
        for (int i = 0; i < 8; i++) begin
            wr(7'b0000001, 26'(i), 16'hA000 + 16'(i));
            if (i == 4) check("t2_wait_after5", ioctl_wait, 1'b0);
            if (i == 5) check("t2_wait_after6", ioctl_wait, 1'b1);
        end
        check("t2_no_ovf", err_ovf, 1'b0);

        // 3: ninth write while full is dropped
        wr(7'b0000001, 26'h8, 16'hA008);
        check("t3_ovf", err_ovf, 1'b1);
        ack_en = 1'b1;
        drain("t2");
        check("t2_wait_clear", ioctl_wait, 1'b0);
        load_en = 1'b0;
        step(); step();
        check("t3_ovf_sticky", err_ovf, 1'b1);
        load_en = 1'b1;
        step();
        check("t3_ovf_cleared", err_ovf, 1'b0);
        ack_en = 1'b0;

        // 4: tiles and sprites together
        wr(7'b0001100, 26'h5, 16'h1234);
        check("t4_multi", err_multi, 1'b1);
        wait_req("t4");
        check("t4_addr", sd.sdram_wr_addr, 24'h080005);
        check("t4_data", sd.sdram_wr_data, 16'h1234);
        ack_en = 1'b1;
        step(); step(); step();
        ack_en = 1'b0;
        // stray ack while idle and empty must not pop anything
        ack_force = 1'b1;
        step();
        ack_force = 1'b0;
        step(); step();
        // address wrap in the 007232 region
        wr(7'b0010000, 26'h2D00001, 16'h5A5A);
        wait_req("wrap");
        check("wrap_addr", sd.sdram_wr_addr, 24'h000001);
        ack_en = 1'b1;
        step(); step(); step();
        ack_en = 1'b0;

        // 5: close the window with three entries queued
        wr(7'b0100000, 26'h1, 16'h0001);
        wr(7'b0001000, 26'h2, 16'h0002);
        wr(7'b0000001, 26'h3, 16'h0003);
        load_en = 1'b0;
        step();
        wr(7'b0000001, 26'h7, 16'hDEAD);
        check("t5_done_busy", dl_done, 1'b0);
        ack_en = 1'b1;
        for (int i = 0; i < 40 && !dl_done; i++) step();
        check("t5_done", dl_done, 1'b1);
        drain("t5");

        // 6: reset while a request is pending
        ack_en = 1'b0;
        load_en = 1'b1;
        step();
        wr(7'b1000000, 26'h9, 16'h9999);
        wr(7'b1000000, 26'hA, 16'hAAAA);
        wait_req("t6");
        check("t6_upd_addr", sd.sdram_wr_addr, 24'h3C0009);
        reset_n = 1'b0;
        #1;
        check("t6_req_async", sd.sdram_wr_req, 1'b0);
        check("t6_wait_async", ioctl_wait, 1'b0);
        check("t6_done_async", dl_done, 1'b0);
        step(); step();
        reset_n = 1'b1;
        ack_en = 1'b1;
        repeat (6) step();
        check("t6_fifo_empty", sd.sdram_wr_req, 1'b0);
        load_en = 1'b0;
        repeat (3) step();
        check("t6_done_after", dl_done, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
